// File: rtl/fd_latch.sv
// Fetch/decode pipeline register: passes fetch results to decode, holds on stall,
// and squashes wrong-path fetches into NOPs for a few cycles after a taken branch.
module fd_latch #(
    parameter int                ADDR_W        = 12,
    parameter int                INSN_W        = 32,
    parameter logic [INSN_W-1:0] NOP           = '0,
    parameter int                SQUASH_CYCLES = 1,
    parameter int                CNT_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INSN_W-1:0] q_imem_f,
    input  logic [ADDR_W-1:0] iaddr_f,
    input  logic [ADDR_W-1:0] next_iaddr_f,
    input  logic              stall_d,
    input  logic              flush_x,
    output logic [INSN_W-1:0] insn_d,
    output logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] next_pc_d,
    output logic              valid_d,
    output logic              squashing,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0]       SQ_INIT = 3'(SQUASH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nx;
    logic [2:0]        sq_cnt, sq_cnt_nx;
    logic [INSN_W-1:0] insn_nx;
    logic [ADDR_W-1:0] pc_nx, next_pc_nx;
    logic              valid_nx;
    logic [CNT_W-1:0]  bubble_nx, stall_nx;
    logic [CNT_W-1:0]  bubble_inc, stall_inc;

    assign squashing  = (state == SQUASH);
    assign bubble_inc = (bubble_count == CNT_MAX) ? bubble_count : bubble_count + CNT_W'(1);
    assign stall_inc  = (stall_count == CNT_MAX) ? stall_count : stall_count + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            sq_cnt       <= 3'd0;
            insn_d       <= NOP;
            pc_d         <= '0;
            next_pc_d    <= '0;
            valid_d      <= 1'b0;
            bubble_count <= '0;
            stall_count  <= '0;
        end else begin
            state        <= state_nx;
            sq_cnt       <= sq_cnt_nx;
            insn_d       <= insn_nx;
            pc_d         <= pc_nx;
            next_pc_d    <= next_pc_nx;
            valid_d      <= valid_nx;
            bubble_count <= bubble_nx;
            stall_count  <= stall_nx;
        end
    end

    // Flush beats stall; a flush keeps the old PC fields so decode still sees
    // where the killed slot came from.
    always_comb begin
        state_nx   = state;
        sq_cnt_nx  = sq_cnt;
        insn_nx    = insn_d;
        pc_nx      = pc_d;
        next_pc_nx = next_pc_d;
        valid_nx   = valid_d;
        bubble_nx  = bubble_count;
        stall_nx   = stall_count;

        if (flush_x) begin
            insn_nx   = NOP;
            valid_nx  = 1'b0;
            state_nx  = SQUASH;
            sq_cnt_nx = SQ_INIT;
            bubble_nx = bubble_inc;
        end else if (stall_d) begin
            stall_nx = stall_inc;
        end else if (state == RUN) begin
            insn_nx    = q_imem_f;
            pc_nx      = iaddr_f;
            next_pc_nx = next_iaddr_f;
            valid_nx   = 1'b1;
        end else begin
            insn_nx    = NOP;
            pc_nx      = iaddr_f;
            next_pc_nx = next_iaddr_f;
            valid_nx   = 1'b0;
            bubble_nx  = bubble_inc;
            if (sq_cnt <= 3'd1) begin
                sq_cnt_nx = 3'd0;
                state_nx  = RUN;
            end else begin
                sq_cnt_nx = sq_cnt - 3'd1;
            end
        end
    end

endmodule
